// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared encodings for the pipeline hazard controller
package pipeline_ctrl_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        MULTI = 1'b1
    } state_t;

    localparam logic [4:0] ZERO_REG     = 5'd0;
    localparam logic [1:0] MEMREAD_NONE = 2'b00;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - parameterised saturating up-counter with async active-low clear
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - ID/EX hazard sequencing: load-use, branch flush, multi-cycle hold
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MULT_LATENCY = 4,
    parameter int MC_W         = 3,
    parameter int CNT_W        = 16
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [4:0]       IFIDRs,
    input  logic [4:0]       IFIDRt,
    input  logic             IFIDUsesRt,
    input  logic             IDMultiCycle,
    input  logic [1:0]       IDEXMemRead,
    input  logic [4:0]       IDEXRt,
    input  logic             BranchTaken,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IFIDFlush,
    output logic             IDEXHazard,
    output logic             IDEXFlush,
    output logic             Busy,
    output logic [CNT_W-1:0] StallCount
);

    state_t          state, state_nxt;
    logic [MC_W-1:0] mc, mc_nxt;
    logic            lu;

    assign lu = (IDEXMemRead != MEMREAD_NONE) && (IDEXRt != ZERO_REG) &&
                ((IDEXRt == IFIDRs) || (IFIDUsesRt && (IDEXRt == IFIDRt)));

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= RUN;
            mc    <= '0;
        end else begin
            state <= state_nxt;
            mc    <= mc_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        mc_nxt     = mc;
        PCWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        IFIDFlush  = 1'b0;
        IDEXHazard = 1'b0;
        IDEXFlush  = 1'b0;
        Busy       = 1'b0;
        if (!Rst_n) begin
            // Outputs must look like a flushed, frozen pipe while reset is held.
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IFIDFlush = 1'b1;
            IDEXFlush = 1'b1;
            state_nxt = RUN;
            mc_nxt    = '0;
        end else begin
            case (state)
                RUN: begin
                    if (BranchTaken) begin
                        IFIDFlush = 1'b1;
                        IDEXFlush = 1'b1;
                    end else if (lu) begin
                        PCWrite    = 1'b0;
                        IFIDWrite  = 1'b0;
                        IDEXHazard = 1'b1;
                    end else if (IDMultiCycle) begin
                        state_nxt = MULTI;
                        mc_nxt    = MC_W'(MULT_LATENCY - 1);
                    end
                end
                MULTI: begin
                    // Operands were captured on entry, so bubbles behind the op are safe.
                    PCWrite    = 1'b0;
                    IFIDWrite  = 1'b0;
                    IDEXHazard = 1'b1;
                    Busy       = 1'b1;
                    if (mc == '0) begin
                        state_nxt = RUN;
                    end else begin
                        mc_nxt = mc - MC_W'(1);
                    end
                end
                default: begin
                    state_nxt = RUN;
                end
            endcase
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (Clk),
        .rst_n(Rst_n),
        .en   (!PCWrite && Rst_n),
        .count(StallCount)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench with a cycle-level behavioural model
module tb_pipeline_hazard_ctrl;

    localparam int LAT = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs, rt, idex_rt;
    logic       uses_rt, multi, branch;
    logic [1:0] memread;

    logic        pcw, ifidw, ifidflush, hazard, idexflush, busy;
    logic [15:0] stall_cnt;
    logic        pcw_s, ifidw_s, ifidflush_s, hazard_s, idexflush_s, busy_s;
    logic [2:0]  stall_cnt_s;

    int tests = 0;
    int fails = 0;

    int multi_left;
    int cnt_big;
    int cnt_small;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MULT_LATENCY(LAT), .MC_W(3), .CNT_W(16)) dut (
        .Clk(clk), .Rst_n(rst_n), .IFIDRs(rs), .IFIDRt(rt), .IFIDUsesRt(uses_rt),
        .IDMultiCycle(multi), .IDEXMemRead(memread), .IDEXRt(idex_rt), .BranchTaken(branch),
        .PCWrite(pcw), .IFIDWrite(ifidw), .IFIDFlush(ifidflush), .IDEXHazard(hazard),
        .IDEXFlush(idexflush), .Busy(busy), .StallCount(stall_cnt)
    );

    pipeline_hazard_ctrl #(.MULT_LATENCY(LAT), .MC_W(3), .CNT_W(3)) dut_sat (
        .Clk(clk), .Rst_n(rst_n), .IFIDRs(rs), .IFIDRt(rt), .IFIDUsesRt(uses_rt),
        .IDMultiCycle(multi), .IDEXMemRead(memread), .IDEXRt(idex_rt), .BranchTaken(branch),
        .PCWrite(pcw_s), .IFIDWrite(ifidw_s), .IFIDFlush(ifidflush_s), .IDEXHazard(hazard_s),
        .IDEXFlush(idexflush_s), .Busy(busy_s), .StallCount(stall_cnt_s)
    );

    function automatic logic model_lu();
        return (memread != 2'b00) && (idex_rt != 5'd0) &&
               ((idex_rt == rs) || (uses_rt && (idex_rt == rt)));
    endfunction

    // {PCWrite, IFIDWrite, IFIDFlush, IDEXHazard, IDEXFlush, Busy}
    function automatic logic [5:0] model_ctrl();
        if (!rst_n)         return 6'b001010;
        if (multi_left > 0) return 6'b000101;
        if (branch)         return 6'b111010;
        if (model_lu())     return 6'b000100;
        return 6'b110000;
    endfunction

    function automatic logic [5:0] obs_ctrl();
        return {pcw, ifidw, ifidflush, hazard, idexflush, busy};
    endfunction

    function automatic logic [5:0] obs_ctrl_s();
        return {pcw_s, ifidw_s, ifidflush_s, hazard_s, idexflush_s, busy_s};
    endfunction

    task automatic model_reset();
        multi_left = 0;
        cnt_big    = 0;
        cnt_small  = 0;
    endtask

    task automatic set_in(input logic [4:0] a_rs, input logic [4:0] a_rt, input logic a_uses,
                          input logic a_multi, input logic [1:0] a_mr, input logic [4:0] a_idrt,
                          input logic a_br);
        rs = a_rs; rt = a_rt; uses_rt = a_uses; multi = a_multi;
        memread = a_mr; idex_rt = a_idrt; branch = a_br;
        #1;
    endtask

    task automatic tick();
        logic [5:0] e;
        logic       enter;
        e     = model_ctrl();
        enter = rst_n && (multi_left == 0) && !branch && !model_lu() && multi;
        @(posedge clk);
        if (rst_n) begin
            if (!e[5]) begin
                if (cnt_big < 65535) cnt_big++;
                if (cnt_small < 7) cnt_small++;
            end
            if (multi_left > 0) multi_left--;
            else if (enter) multi_left = LAT;
        end
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 5'd0, 1'b0);
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        #1;
        tests++;
        if (obs_ctrl() !== 6'b001010) begin
            $display("FAIL reset_ctrl got %b want %b", obs_ctrl(), 6'b001010); fails++;
        end
        tests++;
        if (stall_cnt !== 16'd0) begin
            $display("FAIL reset_count got %0d want 0", stall_cnt); fails++;
        end
        rst_n = 1'b1;
        #1;
        tests++;
        if (obs_ctrl() !== 6'b110000) begin
            $display("FAIL idle_ctrl got %b want %b", obs_ctrl(), 6'b110000); fails++;
        end
    endtask

    task automatic test_load_use();
        do_reset();
        set_in(5'd5, 5'd1, 1'b0, 1'b0, 2'b01, 5'd5, 1'b0);
        tests++;
        if (obs_ctrl() !== 6'b000100) begin
            $display("FAIL lu_ctrl got %b want %b", obs_ctrl(), 6'b000100); fails++;
        end
        tick();
        set_in(5'd5, 5'd1, 1'b0, 1'b0, 2'b00, 5'd0, 1'b0);
        tests++;
        if (stall_cnt !== 16'd1) begin
            $display("FAIL lu_count got %0d want 1", stall_cnt); fails++;
        end
        tests++;
        if (obs_ctrl() !== 6'b110000) begin
            $display("FAIL lu_release got %b want %b", obs_ctrl(), 6'b110000); fails++;
        end
    endtask

    task automatic test_no_stall();
        do_reset();
        set_in(5'd0, 5'd0, 1'b1, 1'b0, 2'b01, 5'd0, 1'b0);
        tests++;
        if (obs_ctrl() !== 6'b110000) begin
            $display("FAIL nostall_r0 got %b want %b", obs_ctrl(), 6'b110000); fails++;
        end
        set_in(5'd3, 5'd5, 1'b0, 1'b0, 2'b10, 5'd5, 1'b0);
        tests++;
        if (obs_ctrl() !== 6'b110000) begin
            $display("FAIL nostall_rt_unused got %b want %b", obs_ctrl(), 6'b110000); fails++;
        end
        set_in(5'd3, 5'd5, 1'b1, 1'b0, 2'b10, 5'd5, 1'b0);
        tests++;
        if (obs_ctrl() !== 6'b000100) begin
            $display("FAIL stall_rt_used got %b want %b", obs_ctrl(), 6'b000100); fails++;
        end
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 5'd0, 1'b0);
    endtask

    task automatic test_multi();
        int busy_cycles = 0;
        int pc_low = 0;
        do_reset();
        set_in(5'd1, 5'd2, 1'b1, 1'b1, 2'b00, 5'd0, 1'b0);
        tests++;
        if (obs_ctrl() !== 6'b110000) begin
            $display("FAIL multi_entry got %b want %b", obs_ctrl(), 6'b110000); fails++;
        end
        tick();
        set_in(5'd1, 5'd2, 1'b1, 1'b0, 2'b00, 5'd0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (busy) busy_cycles++;
            if (!pcw) pc_low++;
            tick();
        end
        tests++;
        if (busy_cycles !== LAT) begin
            $display("FAIL multi_busy_len got %0d want %0d", busy_cycles, LAT); fails++;
        end
        tests++;
        if (pc_low !== LAT) begin
            $display("FAIL multi_pc_low got %0d want %0d", pc_low, LAT); fails++;
        end
        tests++;
        if (stall_cnt !== 16'(LAT)) begin
            $display("FAIL multi_count got %0d want %0d", stall_cnt, LAT); fails++;
        end
    endtask

    task automatic test_branch_priority();
        do_reset();
        set_in(5'd7, 5'd7, 1'b1, 1'b1, 2'b01, 5'd7, 1'b1);
        tests++;
        if (obs_ctrl() !== 6'b111010) begin
            $display("FAIL branch_ctrl got %b want %b", obs_ctrl(), 6'b111010); fails++;
        end
        tick();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 5'd0, 1'b0);
        tests++;
        if (obs_ctrl() !== 6'b110000) begin
            $display("FAIL branch_no_multi got %b want %b", obs_ctrl(), 6'b110000); fails++;
        end
        tests++;
        if (stall_cnt !== 16'd0) begin
            $display("FAIL branch_count got %0d want 0", stall_cnt); fails++;
        end
    endtask

    task automatic test_lu_then_multi();
        do_reset();
        set_in(5'd4, 5'd0, 1'b0, 1'b1, 2'b01, 5'd4, 1'b0);
        tests++;
        if (obs_ctrl() !== 6'b000100) begin
            $display("FAIL lu_multi_first got %b want %b", obs_ctrl(), 6'b000100); fails++;
        end
        tick();
        set_in(5'd4, 5'd0, 1'b0, 1'b1, 2'b00, 5'd4, 1'b0);
        tests++;
        if (obs_ctrl() !== 6'b110000) begin
            $display("FAIL lu_multi_enter got %b want %b", obs_ctrl(), 6'b110000); fails++;
        end
        tick();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 5'd0, 1'b0);
        tests++;
        if (obs_ctrl() !== 6'b000101) begin
            $display("FAIL lu_multi_busy got %b want %b", obs_ctrl(), 6'b000101); fails++;
        end
        for (int i = 0; i < LAT; i++) tick();
        tests++;
        if (stall_cnt !== 16'(cnt_big) || cnt_big != LAT + 1) begin
            $display("FAIL lu_multi_count got %0d want %0d", stall_cnt, LAT + 1); fails++;
        end
    endtask

    task automatic test_reset_mid_multi();
        do_reset();
        set_in(5'd0, 5'd0, 1'b0, 1'b1, 2'b00, 5'd0, 1'b0);
        tick();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 5'd0, 1'b0);
        tick();
        tests++;
        if (obs_ctrl() !== 6'b000101 || stall_cnt !== 16'd1) begin
            $display("FAIL mid_multi_pre got %b/%0d want %b/1", obs_ctrl(), stall_cnt, 6'b000101); fails++;
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        tests++;
        if (obs_ctrl() !== 6'b001010) begin
            $display("FAIL mid_multi_rst_ctrl got %b want %b", obs_ctrl(), 6'b001010); fails++;
        end
        tests++;
        if (stall_cnt !== 16'd0) begin
            $display("FAIL mid_multi_rst_count got %0d want 0", stall_cnt); fails++;
        end
        tick();
        rst_n = 1'b1;
        #1;
        tests++;
        if (obs_ctrl() !== 6'b110000) begin
            $display("FAIL post_rst_run got %b want %b", obs_ctrl(), 6'b110000); fails++;
        end
        set_in(5'd9, 5'd0, 1'b0, 1'b0, 2'b11, 5'd9, 1'b0);
        tick();
        tests++;
        if (stall_cnt !== 16'd1) begin
            $display("FAIL post_rst_lu_count got %0d want 1", stall_cnt); fails++;
        end
    endtask

    task automatic test_saturation();
        do_reset();
        set_in(5'd2, 5'd0, 1'b0, 1'b0, 2'b01, 5'd2, 1'b0);
        for (int i = 0; i < 9; i++) tick();
        tests++;
        if (stall_cnt_s !== 3'd7) begin
            $display("FAIL sat_small got %0d want 7", stall_cnt_s); fails++;
        end
        tests++;
        if (stall_cnt !== 16'd9) begin
            $display("FAIL sat_wide got %0d want 9", stall_cnt); fails++;
        end
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 5'd0, 1'b0);
    endtask

    task automatic test_random();
        int bad = 0;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                   ($urandom_range(0, 5) == 0), 2'($urandom), 5'($urandom_range(0, 3)),
                   ($urandom_range(0, 7) == 0));
            tests++;
            if (obs_ctrl() !== model_ctrl() || obs_ctrl_s() !== model_ctrl() ||
                stall_cnt !== 16'(cnt_big) || stall_cnt_s !== 3'(cnt_small)) begin
                if (bad < 5)
                    $display("FAIL random_cycle%0d got %b/%0d/%0d want %b/%0d/%0d", i, obs_ctrl(),
                             stall_cnt, stall_cnt_s, model_ctrl(), cnt_big, cnt_small);
                bad++;
                fails++;
            end
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        model_reset();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 2'b00, 5'd0, 1'b0);
        test_reset();
        test_load_use();
        test_no_stall();
        test_multi();
        test_branch_priority();
        test_lu_then_multi();
        test_reset_mid_multi();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
